// File: rtl/present_slayer_seq.sv
// PRESENT substitution layer that feeds one nibble per cycle through an external
// registered S-box ROM and reassembles the substituted state for the permutation layer.
module present_slayer_seq #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_state,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [3:0]       sbox_addr,
  output logic             sbox_rd_n,
  input  logic [3:0]       sbox_data,
  output logic [WIDTH-1:0] out_state,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  localparam int NIB   = WIDTH / 4;
  localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NIB - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state_q,   state_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic [CNT_W-1:0] cap_idx_q, cap_idx_d;
  logic             cap_vld_q, cap_vld_d;
  logic [WIDTH-1:0] lat_q,     lat_d;
  logic [WIDTH-1:0] out_q,     out_d;

  // Next-state, counter and latch control
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lat_d   = lat_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          lat_d   = in_state;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = DRAIN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DRAIN: state_d = DONE;
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ROM data lags the read edge by one cycle, so the capture slot trails issue by one.
  always_comb begin
    cap_vld_d = (state_q == RUN);
    cap_idx_d = cnt_q;
    out_d     = out_q;
    if (cap_vld_q) begin
      out_d[int'(cap_idx_q)*4 +: 4] = sbox_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      cap_idx_q <= '0;
      cap_vld_q <= 1'b0;
      lat_q     <= '0;
      out_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cap_idx_q <= cap_idx_d;
      cap_vld_q <= cap_vld_d;
      lat_q     <= lat_d;
      out_q     <= out_d;
    end
  end

  // Outputs decode directly from the state register so reset takes effect at once.
  always_comb begin
    in_ready  = (state_q == IDLE);
    busy      = (state_q != IDLE);
    out_valid = (state_q == DONE);
    sbox_rd_n = 1'b1;
    sbox_addr = '0;
    if (state_q == RUN) begin
      sbox_rd_n = 1'b0;
      sbox_addr = lat_q[int'(cnt_q)*4 +: 4];
    end
  end

  assign out_state = out_q;

endmodule

// File: tb/tb_present_slayer_seq.sv
// Randomized self-checking bench for present_slayer_seq with a behavioural
// registered S-box ROM and a whole-state substitution reference model.
module tb_present_slayer_seq;

  localparam int WIDTH = 64;
  localparam int NIB   = WIDTH / 4;
  localparam logic [3:0] SBOX_T [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                         4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] in_state;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       sbox_addr;
  logic             sbox_rd_n;
  logic [3:0]       sbox_data;
  logic [WIDTH-1:0] out_state;
  logic             out_valid;
  logic             out_ready;
  logic             busy;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  present_slayer_seq #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_state  (in_state),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sbox_addr (sbox_addr),
    .sbox_rd_n (sbox_rd_n),
    .sbox_data (sbox_data),
    .out_state (out_state),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Registered ROM: data appears the cycle after a read edge.
  initial sbox_data = 4'h0;
  always @(posedge clk) begin
    if (!sbox_rd_n) sbox_data <= SBOX_T[sbox_addr];
  end

  function automatic logic [WIDTH-1:0] model_sub(input logic [WIDTH-1:0] s);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < NIB; i++) r[i*4 +: 4] = SBOX_T[s[i*4 +: 4]];
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] rand_state();
    return {$urandom(), $urandom()};
  endfunction

  // Offers one state, follows it to DONE and leaves the DUT there with out_ready low.
  task automatic do_txn(input logic [WIDTH-1:0] st, input bit noise,
                        output logic [WIDTH-1:0] res, output int lat,
                        output int rd_cnt, output logic [WIDTH-1:0] addr_word);
    int w;
    w = 0;
    while (!in_ready && w < 50) begin
      @(posedge clk); #1; w++;
    end
    in_state = st;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0; rd_cnt = 0; addr_word = '0;
    while (lat < 40) begin
      if (!sbox_rd_n) begin
        if (rd_cnt < NIB) addr_word[rd_cnt*4 +: 4] = sbox_addr;
        rd_cnt++;
      end
      if (noise) out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      lat++;
      if (out_valid) break;
    end
    out_ready = 1'b0;
    res = out_state;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_state = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    n_chk++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_chk++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else n_pass++;
    n_chk++; if (sbox_rd_n !== 1'b1) $display("FAIL reset_rd_n: got %b want 1", sbox_rd_n); else n_pass++;
    n_chk++; if (sbox_addr !== 4'h0) $display("FAIL reset_addr: got %h want 0", sbox_addr); else n_pass++;
    n_chk++; if (out_state !== '0) $display("FAIL reset_out_state: got %h want 0", out_state); else n_pass++;
  endtask

  task automatic test_zero();
    logic [WIDTH-1:0] res, aw;
    int lat, rc;
    do_txn('0, 1'b0, res, lat, rc, aw);
    n_chk++; if (res !== 64'hCCCCCCCCCCCCCCCC) $display("FAIL zero_out: got %h want cccccccccccccccc", res); else n_pass++;
    n_chk++; if (lat !== NIB + 1) $display("FAIL zero_latency: got %0d want %0d", lat, NIB + 1); else n_pass++;
    n_chk++; if (rc !== NIB) $display("FAIL zero_reads: got %0d want %0d", rc, NIB); else n_pass++;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_chk++; if (out_valid !== 1'b0) $display("FAIL zero_xfer_valid: got %b want 0", out_valid); else n_pass++;
    n_chk++; if (in_ready !== 1'b1) $display("FAIL zero_xfer_ready: got %b want 1", in_ready); else n_pass++;
  endtask

  task automatic test_vector();
    logic [WIDTH-1:0] st, res, aw;
    int lat, rc;
    st = 64'h0123456789ABCDEF;
    do_txn(st, 1'b0, res, lat, rc, aw);
    n_chk++; if (res !== 64'hC56B90AD3EF84712) $display("FAIL vec_out: got %h want c56b90ad3ef84712", res); else n_pass++;
    n_chk++; if (res !== model_sub(st)) $display("FAIL vec_model: got %h want %h", res, model_sub(st)); else n_pass++;
    n_chk++; if (aw !== st) $display("FAIL vec_addr_seq: got %h want %h", aw, st); else n_pass++;
    n_chk++; if (aw[3:0] !== 4'hF) $display("FAIL vec_first_addr: got %h want f", aw[3:0]); else n_pass++;
    n_chk++; if (rc !== NIB) $display("FAIL vec_reads: got %0d want %0d", rc, NIB); else n_pass++;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [WIDTH-1:0] st, exp, res, aw;
    int lat, rc;
    st  = rand_state();
    exp = model_sub(st);
    do_txn(st, 1'b0, res, lat, rc, aw);
    n_chk++; if (res !== exp) $display("FAIL bp_out: got %h want %h", res, exp); else n_pass++;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      n_chk++; if (out_valid !== 1'b1) $display("FAIL bp_valid[%0d]: got %b want 1", i, out_valid); else n_pass++;
      n_chk++; if (out_state !== exp) $display("FAIL bp_state[%0d]: got %h want %h", i, out_state, exp); else n_pass++;
      n_chk++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready[%0d]: got %b want 0", i, in_ready); else n_pass++;
      n_chk++; if (sbox_rd_n !== 1'b1) $display("FAIL bp_rd_n[%0d]: got %b want 1", i, sbox_rd_n); else n_pass++;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_chk++; if (out_valid !== 1'b0) $display("FAIL bp_xfer_valid: got %b want 0", out_valid); else n_pass++;
    n_chk++; if (in_ready !== 1'b1) $display("FAIL bp_xfer_ready: got %b want 1", in_ready); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] outs [2];
    int acc_cyc [2];
    int n_acc, n_out;
    logic prev_busy;
    outs[0] = '0; outs[1] = '0; acc_cyc[0] = 0; acc_cyc[1] = 0;
    n_acc = 0; n_out = 0;
    in_state  = '1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    prev_busy = busy;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk); #1;
      if (busy && !prev_busy) begin
        if (n_acc < 2) acc_cyc[n_acc] = cyc;
        n_acc++;
        if (n_acc == 1) in_state = '0;
        else in_valid = 1'b0;
      end
      if (out_valid) begin
        if (n_out < 2) outs[n_out] = out_state;
        n_out++;
      end
      prev_busy = busy;
      if (n_out >= 2 && !busy) break;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    n_chk++; if (n_acc !== 2) $display("FAIL b2b_accepts: got %0d want 2", n_acc); else n_pass++;
    n_chk++; if (acc_cyc[1] - acc_cyc[0] !== NIB + 3) $display("FAIL b2b_gap: got %0d want %0d", acc_cyc[1] - acc_cyc[0], NIB + 3); else n_pass++;
    n_chk++; if (n_out !== 2) $display("FAIL b2b_outputs: got %0d want 2", n_out); else n_pass++;
    n_chk++; if (outs[0] !== model_sub('1)) $display("FAIL b2b_out0: got %h want %h", outs[0], model_sub('1)); else n_pass++;
    n_chk++; if (outs[1] !== 64'hCCCCCCCCCCCCCCCC) $display("FAIL b2b_out1: got %h want cccccccccccccccc", outs[1]); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [WIDTH-1:0] st, res, aw;
    int lat, rc;
    bit seen_v;
    st = rand_state();
    in_state = st;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) begin @(posedge clk); #1; end
    n_chk++; if (sbox_addr !== st[7*4 +: 4]) $display("FAIL rstmid_addr7: got %h want %h", sbox_addr, st[7*4 +: 4]); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_chk++; if (sbox_rd_n !== 1'b1) $display("FAIL rstmid_rd_n: got %b want 1", sbox_rd_n); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL rstmid_busy: got %b want 0", busy); else n_pass++;
    n_chk++; if (out_state !== '0) $display("FAIL rstmid_out_state: got %h want 0", out_state); else n_pass++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen_v = 1'b0;
    repeat (25) begin
      @(posedge clk); #1;
      if (out_valid) seen_v = 1'b1;
    end
    n_chk++; if (seen_v !== 1'b0) $display("FAIL rstmid_no_valid: got %b want 0", seen_v); else n_pass++;
    do_txn('0, 1'b0, res, lat, rc, aw);
    n_chk++; if (res !== 64'hCCCCCCCCCCCCCCCC) $display("FAIL rstmid_next: got %h want cccccccccccccccc", res); else n_pass++;
    n_chk++; if (lat !== NIB + 1) $display("FAIL rstmid_latency: got %0d want %0d", lat, NIB + 1); else n_pass++;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_ready_outside_done();
    logic [WIDTH-1:0] st, res, aw;
    int lat, rc;
    out_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    out_ready = 1'b0;
    n_chk++; if (busy !== 1'b0) $display("FAIL idle_rdy_busy: got %b want 0", busy); else n_pass++;
    n_chk++; if (out_valid !== 1'b0) $display("FAIL idle_rdy_valid: got %b want 0", out_valid); else n_pass++;
    st = rand_state();
    do_txn(st, 1'b1, res, lat, rc, aw);
    n_chk++; if (res !== model_sub(st)) $display("FAIL noise_out: got %h want %h", res, model_sub(st)); else n_pass++;
    n_chk++; if (lat !== NIB + 1) $display("FAIL noise_latency: got %0d want %0d", lat, NIB + 1); else n_pass++;
    n_chk++; if (rc !== NIB) $display("FAIL noise_reads: got %0d want %0d", rc, NIB); else n_pass++;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] st, res, aw;
    int lat, rc;
    for (int k = 0; k < 6; k++) begin
      st = rand_state();
      do_txn(st, 1'b0, res, lat, rc, aw);
      n_chk++; if (res !== model_sub(st)) $display("FAIL rand_out[%0d]: got %h want %h", k, res, model_sub(st)); else n_pass++;
      n_chk++; if (aw !== st) $display("FAIL rand_addr_seq[%0d]: got %h want %h", k, aw, st); else n_pass++;
      n_chk++; if (lat !== NIB + 1) $display("FAIL rand_latency[%0d]: got %0d want %0d", k, lat, NIB + 1); else n_pass++;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      n_chk++; if (in_ready !== 1'b1) $display("FAIL rand_xfer_ready[%0d]: got %b want 1", k, in_ready); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_vector();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_ready_outside_done();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
